v_hier_qchg: RTL
================

Name: v_hier_qchg

Overview:
- Change-capture stage directly downstream of v_hier_sub; consumes its 4-bit qvec output.
- Registers qvec every cycle and detects any bit change.
- Each change is queued as a timestamped record {new value, changed-bit mask, time} in a small FIFO.
- Records drain through a valid/ready handshake to a monitor or log stage.

Parameters:
- WIDTH, 4, width of watched vector (matches qvec).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- TSW, 16, timestamp counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- qvec  input  WIDTH  watched vector from v_hier_sub.
- out_valid  output  1  head record available.
- out_ready  input  1  consumer accepts head record.
- out_value  output  WIDTH  qvec value after the change.
- out_mask  output  WIDTH  bits that changed (old XOR new).
- out_time  output  TSW  timer value at capture edge.
- level  output  log2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky: a record was dropped.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values, taking effect on the rising edge where reset=1:
  - out_valid=0, level=0, overflow=0, timer=0, primed=0.
  - out_value, out_mask and out_time=0 while empty.
  - FIFO contents discarded; reset mid-drain flushes all pending records.
- Timer: free-running TSW-bit counter, +1 every non-reset cycle; wraps from 2^TSW-1 to 0 without any flag.
- Sampler: qvec_q <= qvec every non-reset edge; primed <= 1 on the first non-reset edge.
- Priming: the first edge after reset only loads the baseline and never generates a record.
- Change detect (combinational, before edge E): chg = primed && (qvec != qvec_q).
- Record pushed at edge E = {qvec, qvec^qvec_q, timer (pre-increment value)}.
- Latency: a qvec change sampled at edge E appears on the outputs after E (1 cycle) if the FIFO was empty and no older records are pending.
- Back-to-back changes on consecutive cycles each produce their own record.
- FIFO is first-word-fall-through:
  - out_* always reflect the head entry; out_valid = (level != 0).
  - Pop when out_valid && out_ready at an edge.
  - out_ready while empty is ignored.
  - Output data is stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - level unchanged; order preserved.
  - When full, the pop frees space first and the push is accepted (no drop).
- Push while full with no pop: record dropped, overflow <= 1; overflow stays 1 until reset.
- Pointers wrap modulo DEPTH; level saturates at DEPTH.
- No X propagation: a qvec X is compared as-is and is the bench's responsibility; RTL uses no initial blocks.

Optional Feature:
- Macro: V_HIER_QCHG_COALESCE_EN.
- Defined: a push while full with no pop merges into the newest (tail) entry instead of dropping.
  - tail.value <= qvec; tail.mask <= tail.mask | (qvec^qvec_q); tail.time unchanged.
  - overflow stays 0.
  - If the tail is also the head being held (DEPTH entries, all unpopped), merging into the tail still applies; the head is never modified unless head==tail.
- Not defined: drop-and-flag behaviour above; no merge logic is synthesized.

Test Plan:
1. Reset 3 cycles, qvec=4'h0 constant 20 cycles -> out_valid=0, level=0, overflow=0 throughout; first edge after reset creates no record even if qvec=4'h5 there.
2. Primed, out_ready=1, qvec 4'h0->4'h5 at timer=10 -> one cycle later out_valid=1, out_value=4'h5, out_mask=4'h5, out_time=10; popped next edge, level back to 0.
3. out_ready=0, qvec changes on 4 consecutive cycles 1,3,2,6 -> level=4, records drained in order with masks 1,2,1,4 (from 0), time stamps consecutive.
4. FIFO full (DEPTH=4), out_ready=0, fifth change -> without macro: overflow=1, level=4, first 4 records intact; with COALESCE_EN: overflow=0, tail value=new qvec, tail mask=OR of both changes, tail time unchanged.
5. Full FIFO with out_ready=1 and a change on the same edge -> head popped, new record accepted, level stays 4, overflow=0.
6. Assert reset with level=3 mid-drain -> next cycle out_valid=0, level=0, overflow=0, timer=0; the first post-reset edge re-primes with no spurious record.

Source files
------------

// File: rtl/v_hier_qchg.sv
// v_hier_qchg: change-capture stage behind v_hier_sub.
// Timestamps qvec changes into a FWFT FIFO drained by valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   qvec       watched vector (WIDTH bits)
//   out_valid  head record available
//   out_ready  consumer accepts head record
//   out_value  qvec value after the change
//   out_mask   bits that changed (old ^ new)
//   out_time   timer value at the capture edge
//   level      FIFO occupancy (0..DEPTH)
//   overflow   sticky: a record was dropped
//
// Optional build macro: V_HIER_QCHG_COALESCE_EN
//   When defined, a change arriving while the FIFO is full
//   (and nothing pops) merges into the tail record instead
//   of being dropped; overflow then never sets.

module v_hier_qchg #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int TSW   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         qvec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_value,
   output logic [WIDTH-1:0]         out_mask,
   output logic [TSW-1:0]           out_time,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]    LONE  = (AW+1)'(1);
   localparam logic [AW:0]    LFULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]  PONE  = AW'(1);
   localparam logic [TSW-1:0] TONE  = TSW'(1);

   logic [TSW-1:0]   timer;
   logic [WIDTH-1:0] qvec_q;
   logic             primed;

   logic [WIDTH-1:0] mem_val [DEPTH];
   logic [WIDTH-1:0] mem_msk [DEPTH];
   logic [TSW-1:0]   mem_tim [DEPTH];

   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    tl_ptr;

   logic [WIDTH-1:0] dmask;
   logic             chg;
   logic             full;
   logic             pop;
   logic             push;
   logic             blocked;

   // ------------------------------------------------------------
   // Change detect and FIFO control
   // ------------------------------------------------------------
   assign dmask   = qvec ^ qvec_q;
   assign chg     = primed && (qvec != qvec_q);
   assign full    = (level == LFULL);
   assign pop     = out_valid && out_ready;
   // A pop on the same edge frees the slot, so a full FIFO
   // still accepts the new record.
   assign push    = chg && (!full || pop);
   assign blocked = chg && full && !pop;
   assign tl_ptr  = wr_ptr - PONE;

   // ------------------------------------------------------------
   // Timer, sampler and priming
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         timer  <= '0;
         qvec_q <= '0;
         primed <= 1'b0;
      end else begin
         timer  <= timer + TONE;
         qvec_q <= qvec;
         primed <= 1'b1;
      end
   end

   // ------------------------------------------------------------
   // Pointers, occupancy and overflow
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PONE;
         if (pop)
            rd_ptr <= rd_ptr + PONE;
         unique case (1'b1)
            push && !pop: level <= level + LONE;
            pop && !push: level <= level - LONE;
            default: ;
         endcase
`ifndef V_HIER_QCHG_COALESCE_EN
         if (blocked)
            overflow <= 1'b1;
`endif
      end
   end

   // ------------------------------------------------------------
   // Record storage; contents are don't-care outside
   // [rd_ptr, wr_ptr), so no reset is needed here.
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push) begin
            mem_val[wr_ptr] <= qvec;
            mem_msk[wr_ptr] <= dmask;
            mem_tim[wr_ptr] <= timer;
         end
`ifdef V_HIER_QCHG_COALESCE_EN
         else if (blocked) begin
            // Fold into the newest record; its time is kept.
            mem_val[tl_ptr] <= qvec;
            mem_msk[tl_ptr] <= mem_msk[tl_ptr] | dmask;
         end
`endif
      end
   end

`ifndef V_HIER_QCHG_COALESCE_EN
   logic unused_tl;
   assign unused_tl = ^tl_ptr;
`endif

   // ------------------------------------------------------------
   // First-word-fall-through outputs, zeroed while empty
   // ------------------------------------------------------------
   assign out_valid = (level != '0);
   assign out_value = out_valid ? mem_val[rd_ptr] : '0;
   assign out_mask  = out_valid ? mem_msk[rd_ptr] : '0;
   assign out_time  = out_valid ? mem_tim[rd_ptr] : '0;

endmodule
